averager_moving_powers_of_two: RTL and testbench

Sliding-window (boxcar) moving averager over a runtime-selectable power-of-two window of signed samples. Once the window is full it emits one average per accepted sample, unlike a block-averager that emits one result per 2^E samples. Division is by power-of-two, truncating toward zero. It sits between a valid/ready sample source and a valid/ready consumer in filtering and telemetry paths.

---
 rtl/averager_pkg.sv | 14 +
 rtl/divide_signed_by_power_of_two.sv | 21 ++
 rtl/averager_moving_powers_of_two.sv | 116 +++++++++++
 tb/tb_averager_moving_powers_of_two.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/averager_pkg.sv
// Shared definitions for the averager family: window state encoding and
// exponent-port width helper.
package averager_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int exp_width(input int max_exponent);
    return $clog2(max_exponent + 1);
  endfunction

endpackage

// File: rtl/divide_signed_by_power_of_two.sv
// Combinational signed divide by 2^exponent with truncation toward zero;
// the result is narrowed to OUT_W bits.
module divide_signed_by_power_of_two #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 16,
  parameter int EXP_W = 3
) (
  input  logic signed [IN_W-1:0]  dividend,
  input  logic        [EXP_W-1:0] exponent,
  output logic signed [OUT_W-1:0] quotient
);

  logic [IN_W-1:0] bias;

  always_comb begin
    // Negative dividends get 2^E-1 added so the arithmetic shift rounds toward zero.
    bias     = dividend[IN_W-1] ? ~({IN_W{1'b1}} << exponent) : '0;
    quotient = OUT_W'((dividend + $signed(bias)) >>> exponent);
  end

endmodule

// File: rtl/averager_moving_powers_of_two.sv
// Sliding-window moving averager over a runtime power-of-two window of
// signed samples, with valid/ready on both sides.
module averager_moving_powers_of_two
  import averager_pkg::*;
#(
  parameter int WORD_WIDTH   = 16,
  parameter int MAX_EXPONENT = 4
) (
  input  logic                                clock,
  input  logic                                clear,
  input  logic                                restart,
  input  logic [exp_width(MAX_EXPONENT)-1:0]  window_exponent,
  input  logic                                input_valid,
  output logic                                input_ready,
  input  logic signed [WORD_WIDTH-1:0]        input_sample,
  output logic                                output_valid,
  input  logic                                output_ready,
  output logic signed [WORD_WIDTH-1:0]        output_average,
  output logic                                window_full
);

  localparam int EW = exp_width(MAX_EXPONENT);
  localparam int SW = WORD_WIDTH + MAX_EXPONENT;
  localparam int D  = 1 << MAX_EXPONENT;
  localparam int PW = MAX_EXPONENT;
  localparam int CW = MAX_EXPONENT + 1;

  state_t                        state;
  logic        [EW-1:0]          e_reg;
  logic signed [SW-1:0]          sum;
  logic        [CW-1:0]          count;
  logic        [PW-1:0]          wr_ptr;
  logic signed [WORD_WIDTH-1:0]  buffer [D];
  logic signed [WORD_WIDTH-1:0]  avg_p0;
  logic                          vld_p0;

  logic        [CW-1:0]          n_win;
  logic        [PW-1:0]          oldest_idx;
  logic signed [SW-1:0]          sample_ext;
  logic signed [SW-1:0]          oldest_ext;
  logic signed [SW-1:0]          sum_next;
  logic signed [WORD_WIDTH-1:0]  quotient;
  logic        [EW-1:0]          e_clamped;
  logic                          accept;
  logic                          take;
  logic                          fill_done;

  assign input_ready    = !restart && (!vld_p0 || output_ready);
  assign accept         = input_valid && input_ready;
  assign take           = vld_p0 && output_ready;
  assign output_valid   = vld_p0;
  assign output_average = avg_p0;
  assign window_full    = (state == RUN);

  always_comb begin
    n_win      = CW'(1) << e_reg;
    // With N == D the oldest slot is the one about to be overwritten.
    oldest_idx = wr_ptr - n_win[PW-1:0];
    sample_ext = SW'(input_sample);
    oldest_ext = (state == RUN) ? SW'(buffer[oldest_idx]) : '0;
    sum_next   = sum + sample_ext - oldest_ext;
    fill_done  = ((count + CW'(1)) == n_win);
    e_clamped  = (32'(window_exponent) > MAX_EXPONENT) ? EW'(MAX_EXPONENT) : window_exponent;
  end

  divide_signed_by_power_of_two #(
    .IN_W  (SW),
    .OUT_W (WORD_WIDTH),
    .EXP_W (EW)
  ) u_divide (
    .dividend (sum_next),
    .exponent (e_reg),
    .quotient (quotient)
  );

  always_ff @(posedge clock) begin
    if (accept) buffer[wr_ptr] <= input_sample;
  end

  // Stage p0: running sum, window bookkeeping and registered average.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state  <= FILL;
      e_reg  <= EW'(MAX_EXPONENT);
      sum    <= '0;
      count  <= '0;
      wr_ptr <= '0;
      avg_p0 <= '0;
      vld_p0 <= 1'b0;
    end else if (restart) begin
      state  <= FILL;
      e_reg  <= e_clamped;
      sum    <= '0;
      count  <= '0;
      wr_ptr <= '0;
      vld_p0 <= 1'b0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + PW'(1);
      sum    <= sum_next;
      if (state == RUN) begin
        avg_p0 <= quotient;
        vld_p0 <= 1'b1;
      end else begin
        count <= count + CW'(1);
        if (fill_done) begin
          avg_p0 <= quotient;
          vld_p0 <= 1'b1;
          state  <= RUN;
        end
      end
    end else if (take) begin
      vld_p0 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_averager_moving_powers_of_two.sv
// Directed bench for the moving averager at WORD_WIDTH=8, MAX_EXPONENT=3.
module tb_averager_moving_powers_of_two;

  localparam int WW = 8;
  localparam int ME = 3;
  localparam int EW = $clog2(ME + 1);

  logic                 clock = 1'b0;
  logic                 clear = 1'b1;
  logic                 restart = 1'b0;
  logic [EW-1:0]        window_exponent = '0;
  logic                 input_valid = 1'b0;
  logic                 input_ready;
  logic signed [WW-1:0] input_sample = '0;
  logic                 output_valid;
  logic                 output_ready = 1'b1;
  logic signed [WW-1:0] output_average;
  logic                 window_full;

  int total = 0;
  int bad   = 0;

  averager_moving_powers_of_two #(
    .WORD_WIDTH   (WW),
    .MAX_EXPONENT (ME)
  ) dut (
    .clock           (clock),
    .clear           (clear),
    .restart         (restart),
    .window_exponent (window_exponent),
    .input_valid     (input_valid),
    .input_ready     (input_ready),
    .input_sample    (input_sample),
    .output_valid    (output_valid),
    .output_ready    (output_ready),
    .output_average  (output_average),
    .window_full     (window_full)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input int s);
    input_valid  = 1'b1;
    input_sample = WW'(s);
    step();
    input_valid  = 1'b0;
  endtask

  task automatic do_restart(input logic [EW-1:0] e);
    restart         = 1'b1;
    window_exponent = e;
    step();
    restart         = 1'b0;
  endtask

  task automatic check_avg(input string tag, input int expv);
    check({tag, "_vld"}, 32'(output_valid), 1);
    check({tag, "_avg"}, 32'(output_average), expv);
  endtask

  initial begin
    #12;
    clear = 1'b0;
    #1;
    check("rst_vld", 32'(output_valid), 0);
    check("rst_avg", 32'(output_average), 0);
    check("rst_full", 32'(window_full), 0);
    check("rst_rdy", 32'(input_ready), 1);

    // Basic window of four
    do_restart(2'd2);
    push(4); push(8); push(12);
    check("fill_vld", 32'(output_valid), 0);
    check("fill_full", 32'(window_full), 0);
    push(16);
    check_avg("first", 10);
    check("run_full", 32'(window_full), 1);
    push(20);
    check_avg("slide1", 14);
    push(24);
    check_avg("slide2", 18);

    // Truncation toward zero on negatives
    do_restart(2'd2);
    check("rs_vld", 32'(output_valid), 0);
    check("rs_full", 32'(window_full), 0);
    push(-5); push(-5); push(-5); push(-6);
    check_avg("neg21", -5);
    do_restart(2'd2);
    push(-1); push(-1); push(-1); push(0);
    check_avg("neg3", 0);

    // Extremes over a window of eight
    do_restart(2'd3);
    for (int i = 0; i < 8; i++) push(-128);
    check_avg("min", -128);
    do_restart(2'd3);
    for (int i = 0; i < 7; i++) push(127);
    check("max_pre", 32'(output_valid), 0);
    push(127);
    check_avg("max", 127);

    // Backpressure holds the average and blocks input
    output_ready = 1'b0;
    input_valid  = 1'b1;
    input_sample = 8'sd3;
    #1;
    check("bp_rdy", 32'(input_ready), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_avg("bp_hold", 127);
    end
    output_ready = 1'b1;
    #1;
    check("bp_rel_rdy", 32'(input_ready), 1);
    step();
    input_valid = 1'b0;
    check_avg("bp_new", 111);
    step();
    check("bp_drop", 32'(output_valid), 0);

    // Restart mid-fill with a colliding sample
    do_restart(2'd3);
    push(1); push(2); push(3); push(4); push(5);
    restart         = 1'b1;
    window_exponent = 2'd1;
    input_valid     = 1'b1;
    input_sample    = 8'sd100;
    #1;
    check("rs_block", 32'(input_ready), 0);
    step();
    restart     = 1'b0;
    input_valid = 1'b0;
    push(2);
    check("rs_fill", 32'(output_valid), 0);
    push(4);
    check_avg("rs_e1", 3);

    // Largest encodable exponent gives the full window of eight
    do_restart('1);
    for (int i = 1; i <= 7; i++) push(i);
    check("cl_pre", 32'(output_valid), 0);
    push(8);
    check_avg("cl_e3", 4);

    // Window of one echoes every sample
    do_restart(2'd0);
    push(7);
    check_avg("e0_a", 7);
    check("e0_full", 32'(window_full), 1);
    push(-3);
    check_avg("e0_b", -3);

    // Asynchronous clear between edges
    @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    check("clr_vld", 32'(output_valid), 0);
    check("clr_avg", 32'(output_average), 0);
    check("clr_full", 32'(window_full), 0);
    #2;
    clear = 1'b0;
    for (int i = 0; i < 7; i++) push(9);
    check("clr_pre", 32'(output_valid), 0);
    push(9);
    check_avg("clr_e3", 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
